// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Bundles the host load stream, the PC/decode control and the fetch results
// of the instruction fetch stage.
//
// Signals (direction as seen by the fetch stage, i.e. the slave modport):
//   load_valid_i  in   load_data_i holds a program word this cycle
//   load_data_i   in   IW-bit program word
//   load_last_i   in   final word of the program (qualifies load_valid_i)
//   start_i       in   begin/resume execution
//   pc_i          in   W-bit fetch address
//   stall_i       in   decode not ready, hold current instruction
//   flush_i       in   squash current instruction
//   instr_o       out  fetched instruction register
//   instr_valid_o out  instr_o is a live instruction
//   loading_c     out  stage is in LOAD (combinational decode of state)
//   done_o        out  HALT retired, sticky until start or reset
//   load_err_o    out  sticky, load attempted past end of memory
//   load_count_o  out  W+1-bit count of words accepted since reset
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 9
) ();

    logic          load_valid_i;
    logic [IW-1:0] load_data_i;
    logic          load_last_i;
    logic          start_i;
    logic [W-1:0]  pc_i;
    logic          stall_i;
    logic          flush_i;
    logic [IW-1:0] instr_o;
    logic          instr_valid_o;
    logic          loading_c;
    logic          done_o;
    logic          load_err_o;
    logic [W:0]    load_count_o;

    // Fetch stage side
    modport slave (
        input  load_valid_i, load_data_i, load_last_i,
        input  start_i, pc_i, stall_i, flush_i,
        output instr_o, instr_valid_o, loading_c,
        output done_o, load_err_o, load_count_o
    );

    // Host / pipeline side
    modport master (
        output load_valid_i, load_data_i, load_last_i,
        output start_i, pc_i, stall_i, flush_i,
        input  instr_o, instr_valid_o, loading_c,
        input  done_o, load_err_o, load_count_o
    );

endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage of the 8-bit CPU. Owns a 2**W x IW instruction
// memory. In LOAD it writes a byte-serial program image from the host; in RUN
// it performs a registered synchronous read at the PC and hands the word to
// decode with valid/stall/flush control. Detects HALT_OP and reports Done.
//
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset, returns the stage to LOAD
//   bus  instr_fetch_if.slave (load stream, PC, stall/flush, fetch results)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned   W       = 8,
    parameter int unsigned   IW      = 9,
    parameter logic [IW-1:0] HALT_OP = {IW{1'b1}}
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** W;
    localparam int unsigned CNT_W = W + 1;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        IDLE   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_e;

    state_e           state_q;
    logic [IW-1:0]    instr_q;
    logic             instr_valid_q;
    logic             done_q;
    logic             load_err_q;
    logic [CNT_W-1:0] load_count_q;

    // Not reset: the program image survives a reset
    logic [IW-1:0] mem [DEPTH];

    logic load_full_c;
    logic mem_we_c;

    // Count saturates at DEPTH, which is also the "memory full" condition
    assign load_full_c = (load_count_q == CNT_W'(DEPTH));

    // Writes only in LOAD and never while reset is asserted
    assign mem_we_c = (state_q == LOAD) && bus.load_valid_i && !load_full_c && !rst;

    // Program memory write port
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[load_count_q[W-1:0]] <= bus.load_data_i;
        end
    end

    // Control FSM and registered fetch outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOAD;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            load_err_q    <= 1'b0;
            load_count_q  <= '0;
        end else begin
            unique case (state_q)
                LOAD: begin
                    // A load word takes priority over a simultaneous start
                    if (bus.load_valid_i) begin
                        if (load_full_c) begin
                            load_err_q <= 1'b1;
                        end else begin
                            load_count_q <= load_count_q + CNT_W'(1);
                        end
                        if (bus.load_last_i) begin
                            state_q <= IDLE;
                        end
                    end else if (bus.start_i) begin
                        state_q <= RUN;
                    end
                end

                IDLE: begin
                    if (bus.start_i) begin
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (bus.flush_i) begin
                        instr_q       <= '0;
                        instr_valid_q <= 1'b0;
                    end else if (bus.stall_i) begin
                        // Hold instr/valid; HALT detection waits for the stall to drop
                        instr_q       <= instr_q;
                        instr_valid_q <= instr_valid_q;
                    end else if (instr_valid_q && (instr_q == HALT_OP)) begin
                        // HALT retires: keep the HALT word visible, drop valid
                        state_q       <= HALTED;
                        instr_valid_q <= 1'b0;
                        done_q        <= 1'b1;
                    end else begin
                        instr_q       <= mem[bus.pc_i];
                        instr_valid_q <= 1'b1;
                    end
                end

                HALTED: begin
                    if (bus.start_i) begin
                        state_q <= RUN;
                        done_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

    assign bus.instr_o       = instr_q;
    assign bus.instr_valid_o = instr_valid_q;
    assign bus.loading_c     = (state_q == LOAD);
    assign bus.done_o        = done_q;
    assign bus.load_err_o    = load_err_q;
    assign bus.load_count_o  = load_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. The stimulus process pushes each instruction
// it expects to see on instr_o into a queue; an independent monitor pops and
// compares on every cycle the DUT presents instr_valid_o. Status outputs are
// compared directly against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_if #(.W(W), .IW(IW)) bus ();

    instr_fetch #(.W(W), .IW(IW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] prog [4] = '{9'h010, 9'h021, 9'h032, 9'h1FF};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: one expected word per valid cycle
    always @(negedge clk) begin
        if (!rst && bus.instr_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid actual=%0h required=no_valid", bus.instr_o);
            end else begin
                chk("instr_stream", 32'(bus.instr_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load_valid_i = 1'b0;
        bus.load_data_i  = '0;
        bus.load_last_i  = 1'b0;
        bus.start_i      = 1'b0;
        bus.pc_i         = '0;
        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_instr",      32'(bus.instr_o),       32'h0);
        chk("rst_valid",      32'(bus.instr_valid_o), 32'h0);
        chk("rst_done",       32'(bus.done_o),        32'h0);
        chk("rst_err",        32'(bus.load_err_o),    32'h0);
        chk("rst_count",      32'(bus.load_count_o),  32'h0);
        chk("rst_loading",    32'(bus.loading_c),     32'h1);
        rst = 1'b0;

        // Load 4-word program
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = prog[i];
            bus.load_last_i  = (i == 3);
        end
        @(negedge clk);
        bus.load_valid_i = 1'b0;
        bus.load_last_i  = 1'b0;
        chk("load4_count",    32'(bus.load_count_o),  32'd4);
        chk("load4_loading",  32'(bus.loading_c),     32'h0);
        chk("load4_err",      32'(bus.load_err_o),    32'h0);

        // IDLE ignores load inputs
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 9'h155;
        bus.load_last_i  = 1'b1;
        @(negedge clk);
        bus.load_valid_i = 1'b0;
        bus.load_last_i  = 1'b0;
        chk("idle_count",     32'(bus.load_count_o),  32'd4);
        chk("idle_valid",     32'(bus.instr_valid_o), 32'h0);

        // Run PC 0..3, HALT retires one cycle after it appears
        bus.start_i = 1'b1;
        bus.pc_i    = 8'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        exp_q.push_back(prog[0]);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            bus.pc_i = W'(i);
            exp_q.push_back(prog[i]);
        end
        @(negedge clk);
        bus.pc_i = 8'd0;
        chk("halt_done_early", 32'(bus.done_o),       32'h0);
        @(negedge clk);
        chk("halt_done",       32'(bus.done_o),       32'h1);
        chk("halt_valid",      32'(bus.instr_valid_o), 32'h0);
        chk("halt_instr_hold", 32'(bus.instr_o),      32'h1FF);

        // Resume at PC 1, then stall two cycles with PC changing
        bus.start_i = 1'b1;
        bus.pc_i    = 8'd1;
        @(negedge clk);
        bus.start_i = 1'b0;
        exp_q.push_back(9'h021);
        chk("resume_done_clr", 32'(bus.done_o),       32'h0);
        @(negedge clk);
        bus.stall_i = 1'b1;
        bus.pc_i    = 8'd2;
        exp_q.push_back(9'h021);
        @(negedge clk);
        bus.pc_i    = 8'd3;
        exp_q.push_back(9'h021);
        @(negedge clk);
        bus.stall_i = 1'b0;
        bus.pc_i    = 8'd2;
        exp_q.push_back(9'h032);
        @(negedge clk);
        bus.pc_i = 8'd3;
        exp_q.push_back(9'h1FF);

        // Flush + stall while HALT word is current
        @(negedge clk);
        bus.flush_i = 1'b1;
        bus.stall_i = 1'b1;
        bus.pc_i    = 8'd0;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        exp_q.push_back(9'h010);
        chk("flush_instr",     32'(bus.instr_o),       32'h0);
        chk("flush_valid",     32'(bus.instr_valid_o), 32'h0);
        chk("flush_done",      32'(bus.done_o),        32'h0);
        @(negedge clk);
        bus.pc_i = 8'd1;
        exp_q.push_back(9'h021);

        // HALT under stall waits for stall release
        @(negedge clk);
        bus.pc_i = 8'd3;
        exp_q.push_back(9'h1FF);
        @(negedge clk);
        bus.stall_i = 1'b1;
        exp_q.push_back(9'h1FF);
        @(negedge clk);
        bus.stall_i = 1'b0;
        chk("stall_halt_wait", 32'(bus.done_o),        32'h0);
        @(negedge clk);
        chk("stall_halt_done", 32'(bus.done_o),        32'h1);
        chk("stall_halt_vld",  32'(bus.instr_valid_o), 32'h0);

        // Reset mid-RUN with load traffic present during reset
        bus.start_i = 1'b1;
        bus.pc_i    = 8'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        exp_q.push_back(9'h010);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 9'h0AA;
        #1;
        chk("arst_instr",      32'(bus.instr_o),       32'h0);
        chk("arst_valid",      32'(bus.instr_valid_o), 32'h0);
        chk("arst_loading",    32'(bus.loading_c),     32'h1);
        chk("arst_count",      32'(bus.load_count_o),  32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.load_valid_i = 1'b0;
        chk("arst_count_hold", 32'(bus.load_count_o),  32'h0);

        // Start from LOAD reuses the retained image
        bus.start_i = 1'b1;
        bus.pc_i    = 8'd1;
        @(negedge clk);
        bus.start_i = 1'b0;
        exp_q.push_back(9'h021);
        chk("start_load_ld",   32'(bus.loading_c),     32'h0);
        @(negedge clk);
        bus.pc_i = 8'd0;
        exp_q.push_back(9'h010);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Overflow load: 256 words fill memory, 257th is rejected
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            bus.load_valid_i = 1'b1;
            bus.load_data_i  = IW'(i + 3);
            bus.load_last_i  = 1'b0;
        end
        @(negedge clk);
        chk("full_count",      32'(bus.load_count_o),  32'd256);
        chk("full_err",        32'(bus.load_err_o),    32'h0);
        chk("full_loading",    32'(bus.loading_c),     32'h1);
        bus.load_data_i = 9'h0CC;
        bus.load_last_i = 1'b1;
        @(negedge clk);
        bus.load_valid_i = 1'b0;
        bus.load_last_i  = 1'b0;
        chk("ovf_count",       32'(bus.load_count_o),  32'd256);
        chk("ovf_err",         32'(bus.load_err_o),    32'h1);
        chk("ovf_loading",     32'(bus.loading_c),     32'h0);

        // mem[0] keeps first word; mem[255] holds last accepted word
        bus.start_i = 1'b1;
        bus.pc_i    = 8'd0;
        @(negedge clk);
        bus.start_i = 1'b0;
        exp_q.push_back(9'h003);
        @(negedge clk);
        bus.pc_i = 8'd255;
        exp_q.push_back(9'h102);
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 8-bit custom CPU, sitting directly downstream of the program counter. It owns the instruction memory and has two modes. In load mode it loads a program from a byte-serial host stream. In run mode it reads the instruction addressed by the PC through a registered synchronous read, and presents it to decode with valid, stall and flush control. It also detects the HALT opcode and reports program completion.

## Interface
- W, 8, PC/address width; memory depth is 2**W words
- IW, 9, instruction width
- HALT_OP, {IW{1'b1}}, opcode that ends execution
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high; returns block to LOAD
- LoadValid  input  1  LoadData is valid this cycle (LOAD only)
- LoadData  input  IW  instruction word to write
- LoadLast  input  1  qualifies LoadValid; this is the final word of the program
- Start  input  1  begin/resume execution
- PC  input  W  fetch address from program counter
- Stall  input  1  hold current instruction (decode not ready)
- Flush  input  1  squash current instruction (taken branch)
- Instr  output  IW  fetched instruction register
- InstrValid  output  1  Instr is a live instruction
- Loading  output  1  state == LOAD
- Done  output  1  HALT retired; sticky until Start or Reset
- LoadErr  output  1  sticky; load attempted past end of memory
- LoadCount  output  W+1  words accepted since reset

## Operation
- States: LOAD, IDLE, RUN, HALTED. Reset forces LOAD. The memory array itself is not reset; its contents survive Reset.
- LOAD:
  - LoadValid with LoadCount < 2**W: write mem[LoadCount[W-1:0]] <= LoadData, LoadCount++.
  - LoadValid with LoadCount == 2**W: no write, LoadErr <= 1, count holds.
  - LoadValid & LoadLast: perform the write rule above, then go to IDLE.
  - Start without LoadValid: go directly to RUN, reusing the existing memory image.
  - Start together with LoadValid: the load takes priority and Start is ignored.
- IDLE: Start goes to RUN. All load inputs are ignored.
- RUN, evaluated every edge in this priority order:
  - Flush: Instr <= 0, InstrValid <= 0. Overrides both Stall and halt detection.
  - Stall: Instr and InstrValid hold. PC is not sampled.
  - InstrValid & Instr == HALT_OP: go to HALTED, InstrValid <= 0, Done <= 1. Instr holds the HALT word.
  - Otherwise: Instr <= mem[PC], InstrValid <= 1.
- HALTED: Instr holds and InstrValid stays 0. Start goes to RUN and clears Done; the next instruction is fetched from the current PC.
- Start in RUN is ignored. LoadValid outside LOAD is ignored.
- Loading is decoded combinationally from the state.

## Timing
- Reset values: Instr = 0, InstrValid = 0, Done = 0, LoadErr = 0, LoadCount = 0, Loading = 1. All take effect immediately on Reset assertion (asynchronous).
- Load write: one word per cycle, no backpressure. LoadCount is updated on the same edge as the write.
- Start sampled at edge k (from IDLE, LOAD or HALTED):
  - state is RUN after k;
  - edge k+1 captures mem[PC];
  - Instr and InstrValid = 1 are visible after k+1.
- Fetch latency is one cycle: a PC value stable before edge n yields Instr after edge n.
- Flush asserted before edge n gives a one-cycle bubble after n. Fetch resumes at edge n+1 from the PC presented at that edge.
- A HALT word appearing on Instr after edge n sets Done after edge n+1, provided there is no Stall or Flush at n+1. Under Stall, detection waits until Stall drops.
- Reset asserted mid-RUN: all registers clear asynchronously and the block enters LOAD. No memory write occurs during Reset.
- LoadCount saturates at 2**W and never wraps.

## Test plan
- Reset, load 4 words 9'h010, 9'h021, 9'h032 and 9'h1FF (LoadLast on the 4th) -> LoadCount = 4, state IDLE, LoadErr = 0.
- Start, PC = 0, 1, 2, 3 on successive cycles -> Instr = 010, 021, 032, 1FF with InstrValid = 1 from the cycle after Start+1. One cycle later Done = 1, InstrValid = 0.
- Stall high for 2 cycles while Instr = 021, with PC changing -> Instr holds at 021 and InstrValid holds at 1. On Stall release the next fetch reads the new PC.
- Flush and Stall together while Instr = 1FF -> Instr = 0, InstrValid = 0, Done stays 0, execution continues from the next PC.
- Load 257 words, with LoadLast on the 257th -> LoadCount = 256, LoadErr = 1, mem[0] not overwritten by the 257th word, state IDLE.
- Reset mid-RUN, then Start in LOAD with PC = 1 -> Loading drops, and Instr = 021 one cycle later, showing the memory image was retained.
